bsg_manycore_edge_endpoint: RTL
===============================

Name: bsg_manycore_edge_endpoint

Overview:
- Host-side endpoint attached to one boundary port (hor or ver, one row/column) of the manycore mesh array.
- Forms request packets from a host command interface and injects them into the array edge port.
- Accepts packets leaving the array through the same edge, buffers them, and presents them to the host.
- Both directions are decoupled by FIFOs, and the block keeps saturating traffic and error counters.

Parameters:
x_cord_width_p, 2, x coordinate field width
y_cord_width_p, 2, y coordinate field width
addr_width_p, 32, address field width
data_width_p, 32, data field width
fifo_els_p, 2, depth of each of tx and rx FIFOs (power of two, >=2)
count_width_p, 16, width of statistics counters
packet_width_lp, 6+x_cord_width_p+y_cord_width_p+addr_width_p+data_width_p, edge packet width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
my_x_i  in  x_cord_width_p  this endpoint's x coordinate
my_y_i  in  y_cord_width_p  this endpoint's y coordinate
req_v_i  in  1  host request valid
req_ready_o  out  1  tx FIFO not full
req_op_i  in  2  opcode
req_mask_i  in  4  byte mask
req_x_i  in  x_cord_width_p  destination x
req_y_i  in  y_cord_width_p  destination y
req_addr_i  in  addr_width_p  address
req_data_i  in  data_width_p  data
link_data_o  out  packet_width_lp  packet into array edge
link_v_o  out  1  packet valid
link_ready_i  in  1  array edge ready
link_data_i  in  packet_width_lp  packet leaving array edge
link_v_i  in  1  incoming valid
link_ready_o  out  1  rx FIFO not full
resp_v_o  out  1  rx head valid
resp_data_o  out  packet_width_lp  rx head packet
resp_mismatch_o  out  1  rx head dest coords != my_x_i/my_y_i
resp_yumi_i  in  1  host consumes rx head (legal only when resp_v_o=1)
tx_count_o  out  count_width_p  packets sent
rx_count_o  out  count_width_p  packets received
err_count_o  out  count_width_p  mismatched packets received

Behaviour:
- Packet layout, MSB to LSB: data, addr, op[1:0], mask[3:0], y_cord, x_cord. The request is packed as {req_data_i, req_addr_i, req_op_i, req_mask_i, req_y_i, req_x_i}.
- Reset (reset_n_i=0, asynchronous):
  - Both FIFOs empty; all counters 0.
  - link_v_o=0, resp_v_o=0, resp_mismatch_o=0.
  - req_ready_o=0 and link_ready_o=0 while reset is asserted; both become 1 in the first cycle after deassertion.
  - Mid-operation reset discards all buffered packets immediately.
- Tx path:
  - Enqueue when req_v_i & req_ready_o.
  - A packet accepted at edge N drives link_v_o=1 with that packet in cycle N+1 (registered FIFO storage, no bypass).
  - Dequeue when link_v_o & link_ready_i.
  - link_data_o is held stable while link_v_o=1 and link_ready_i=0.
  - req_ready_o = !full. When full, a same-cycle dequeue does not re-open ready until the next cycle.
  - FIFO order is strictly preserved. Read and write pointers wrap modulo fifo_els_p.
  - Simultaneous enqueue and dequeue on a non-empty, non-full FIFO leaves occupancy unchanged.
- Rx path:
  - Same FIFO rules. Enqueue on link_v_i & link_ready_o; dequeue on resp_yumi_i.
  - Packet accepted at edge N appears on resp_v_o in cycle N+1.
  - resp_mismatch_o is combinational on the head: (head.y_cord!=my_y_i)|(head.x_cord!=my_x_i).
  - Mismatched packets are still delivered, never dropped.
  - resp_yumi_i with resp_v_o=0 is illegal; the bench asserts on it and the RTL ignores it.
- Counters:
  - tx_count_o increments on each tx dequeue.
  - rx_count_o increments on each rx enqueue.
  - err_count_o increments on each rx enqueue whose incoming packet coordinates mismatch my_x_i/my_y_i.
  - All counters saturate at 2^count_width_p-1 with no wrap.
- Ready behaviour: neither ready output depends combinationally on the opposite side's ready/valid (no combinational path link_ready_i->req_ready_o or resp_yumi_i->link_ready_o).

Test Plan:
- Reset, then single request (op=1, mask=4'hF, x=1, y=2, addr=0x100, data=0xDEADBEEF) with link_ready_i=1 -> link_v_o=1 exactly one cycle after acceptance, fields at defined positions, tx_count_o=1.
- link_ready_i=0, push 3 requests with fifo_els_p=2 -> req_ready_o=0 after 2 accepted, third held. Release link_ready_i -> 3 packets emerge in order, data stable during stall, tx_count_o=3.
- Incoming packet with x=my_x_i, y=my_y_i, then one with x=my_x_i+1 -> resp_mismatch_o 0 then 1, rx_count_o=2, err_count_o=1, both delivered in order.
- resp_yumi_i held 0 while 2 packets arrive -> link_ready_o=0. Yumi one -> link_ready_o=1 next cycle. Continuous streaming with yumi every cycle -> one packet per cycle, no loss.
- Assert reset_n_i mid-stream with both FIFOs holding 2 entries -> link_v_o, resp_v_o and all counters 0 immediately (asynchronous). After release, first new request emerges intact.
- count_width_p=4, send 20 packets -> tx_count_o stops at 15.

Source files
------------

// File: rtl/bsg_manycore_edge_endpoint.sv
// Host endpoint on one manycore edge port: request tx FIFO,
// response rx FIFO and saturating traffic/error counters.

module bsg_manycore_edge_endpoint_fifo #(
  parameter int width_p = 8,
  parameter int els_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [ptr_w_lp:0] full_lp = (ptr_w_lp+1)'(els_p);
  localparam logic [ptr_w_lp:0] one_lp = 1;
  localparam logic [ptr_w_lp-1:0] pone_lp = 1;

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [ptr_w_lp:0]   cnt_r, cnt_n;
  logic                ready_r;
  logic                enq, deq;

  assign enq = v_i & ready_r;
  assign deq = yumi_i & v_o;
  assign v_o = (cnt_r != '0);
  assign ready_o = ready_r;
  assign data_o = mem_r[rptr_r];

  // occupancy after this edge's enqueue/dequeue
  always_comb begin
    cnt_n = cnt_r;
    if (enq & ~deq) cnt_n = cnt_r + one_lp;
    else if (deq & ~enq) cnt_n = cnt_r - one_lp;
  end

  // pointers, occupancy and registered ready (low in reset)
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      cnt_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      if (enq) wptr_r <= wptr_r + pone_lp;
      if (deq) rptr_r <= rptr_r + pone_lp;
      cnt_r   <= cnt_n;
      ready_r <= (cnt_n != full_lp);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end
endmodule

module bsg_manycore_edge_endpoint #(
  parameter int x_cord_width_p = 2,
  parameter int y_cord_width_p = 2,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int fifo_els_p = 2,
  parameter int count_width_p = 16,
  localparam int packet_width_lp = 6 + x_cord_width_p
    + y_cord_width_p + addr_width_p + data_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  input  logic                       req_v_i,
  output logic                       req_ready_o,
  input  logic [1:0]                 req_op_i,
  input  logic [3:0]                 req_mask_i,
  input  logic [x_cord_width_p-1:0]  req_x_i,
  input  logic [y_cord_width_p-1:0]  req_y_i,
  input  logic [addr_width_p-1:0]    req_addr_i,
  input  logic [data_width_p-1:0]    req_data_i,
  output logic [packet_width_lp-1:0] link_data_o,
  output logic                       link_v_o,
  input  logic                       link_ready_i,
  input  logic [packet_width_lp-1:0] link_data_i,
  input  logic                       link_v_i,
  output logic                       link_ready_o,
  output logic                       resp_v_o,
  output logic [packet_width_lp-1:0] resp_data_o,
  output logic                       resp_mismatch_o,
  input  logic                       resp_yumi_i,
  output logic [count_width_p-1:0]   tx_count_o,
  output logic [count_width_p-1:0]   rx_count_o,
  output logic [count_width_p-1:0]   err_count_o
);
  localparam int xw_lp = x_cord_width_p;
  localparam int yw_lp = y_cord_width_p;
  localparam logic [count_width_p-1:0] cone_lp = 1;

  logic [packet_width_lp-1:0] req_pkt;
  logic tx_deq, rx_enq, in_mis, head_mis;

  assign req_pkt = {req_data_i, req_addr_i, req_op_i,
                    req_mask_i, req_y_i, req_x_i};

  bsg_manycore_edge_endpoint_fifo #(
    .width_p(packet_width_lp),
    .els_p(fifo_els_p)
  ) tx_fifo (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .data_i(req_pkt),
    .v_i(req_v_i),
    .ready_o(req_ready_o),
    .data_o(link_data_o),
    .v_o(link_v_o),
    .yumi_i(link_ready_i)
  );

  bsg_manycore_edge_endpoint_fifo #(
    .width_p(packet_width_lp),
    .els_p(fifo_els_p)
  ) rx_fifo (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .data_i(link_data_i),
    .v_i(link_v_i),
    .ready_o(link_ready_o),
    .data_o(resp_data_o),
    .v_o(resp_v_o),
    .yumi_i(resp_yumi_i)
  );

  assign tx_deq = link_v_o & link_ready_i;
  assign rx_enq = link_v_i & link_ready_o;

  assign in_mis =
    (link_data_i[xw_lp+:yw_lp] != my_y_i)
    | (link_data_i[xw_lp-1:0] != my_x_i);

  assign head_mis =
    (resp_data_o[xw_lp+:yw_lp] != my_y_i)
    | (resp_data_o[xw_lp-1:0] != my_x_i);

  assign resp_mismatch_o = resp_v_o & head_mis;

  // saturating tx/rx/error counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_count_o  <= '0;
      rx_count_o  <= '0;
      err_count_o <= '0;
    end else begin
      if (tx_deq && tx_count_o != '1)
        tx_count_o <= tx_count_o + cone_lp;
      if (rx_enq && rx_count_o != '1)
        rx_count_o <= rx_count_o + cone_lp;
      if (rx_enq && in_mis && err_count_o != '1)
        err_count_o <= err_count_o + cone_lp;
    end
  end
endmodule
